// File: rtl/bus_data_buffer.sv
// Small FIFO data buffer with sticky overflow/underflow flags and a hold register.
// Define BUS_DATA_BUFFER_BYPASS_EN to pass a same-cycle write+read straight through when empty.
module bus_data_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clk_en,
  input  logic                       i_clear,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hold;
  logic             ovf;
  logic             unf;

  logic empty;
  logic full;
  logic byp;
  logic rd_ok;
  logic wr_ok;
  logic ovf_ev;
  logic unf_ev;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef BUS_DATA_BUFFER_BYPASS_EN
  assign byp = empty && i_wr_en && i_rd_en;
`else
  assign byp = 1'b0;
`endif

  assign rd_ok  = i_rd_en && !empty;
  assign wr_ok  = i_wr_en && !byp && (!full || rd_ok);
  assign ovf_ev = i_wr_en && full && !rd_ok;
  assign unf_ev = i_rd_en && empty && !byp;

  always_ff @(posedge i_clk) begin
    if (!i_reset && i_clk_en && !i_clear && wr_ok)
      mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (i_clk_en) begin
      if (i_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        unf    <= 1'b0;
      end else begin
        if (wr_ok)
          wr_ptr <= wr_ptr + AW'(1);
        if (rd_ok) begin
          hold   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (byp)
          hold <= i_data;
        if (wr_ok && !rd_ok)
          count <= count + CW'(1);
        else if (rd_ok && !wr_ok)
          count <= count - CW'(1);
        if (ovf_ev)
          ovf <= 1'b1;
        if (unf_ev)
          unf <= 1'b1;
      end
    end
  end

  // Empty shows the last popped word rather than stale storage
  always_comb begin
    o_data = empty ? hold : mem[rd_ptr];
    if (byp && i_clk_en)
      o_data = i_data;
  end

`ifdef BUS_DATA_BUFFER_BYPASS_EN
  assign o_valid = !empty || (i_clk_en && i_wr_en);
`else
  assign o_valid = !empty;
`endif

  assign o_full      = full;
  assign o_count     = count;
  assign o_overflow  = ovf;
  assign o_underflow = unf;

endmodule
